reg_writeback_unit: RTL and testbench

REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

---
 rtl/mips_pkg.sv | 38 +++
 rtl/wb_fifo.sv | 45 ++++
 rtl/reg_writeback_unit.sv | 108 ++++++++++
 tb/tb_reg_writeback_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the register writeback unit
package mips_pkg;

   localparam int WB_QDEPTH = 4;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        is_byte;
      logic [1:0]  lane;
   } wb_entry_t;

   function automatic logic [31:0] merge_byte(input logic [31:0] old,
                                              input logic [7:0]  b,
                                              input logic [1:0]  lane);
      logic [31:0] r;
      r = old;
      case (lane)
         LANE_B0: r[7:0]   = b;
         LANE_B1: r[15:8]  = b;
         LANE_B2: r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous first-word-fall-through queue with occupancy count
module wb_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full refuses a push even when a pop happens in the same cycle.
   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - in-order register writeback queue with byte read-modify-write
module reg_writeback_unit
   import mips_pkg::*;
#(
   parameter int QDEPTH = WB_QDEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   input  logic        wb_byte,
   input  logic [1:0]  wb_byte_sel,
   output logic [4:0]  rf_read_reg,
   input  logic [31:0] rf_read_data,
   output logic [4:0]  rf_write_reg,
   output logic [31:0] rf_write_data,
   output logic        rf_reg_write,
   output logic        busy
);
   localparam int CW = $clog2(QDEPTH) + 1;
   localparam int EW = $bits(wb_entry_t);

   wb_state_t     state;
   wb_entry_t     in_entry;
   wb_entry_t     head;
   logic [EW-1:0] head_bits;
   logic [CW-1:0] count;
   logic [CW-1:0] next_count;
   logic          push;
   logic          pop;
   logic [7:0]    pend_byte;
   logic [1:0]    pend_lane;

   assign in_entry   = '{rd: wb_reg, data: wb_data, is_byte: wb_byte, lane: wb_byte_sel};
   assign wb_ready   = (count != CW'(QDEPTH));
   assign push       = wb_valid && wb_ready;
   // The head is taken whenever the FSM is free to issue: from IDLE or right behind a write.
   assign pop        = (state != ST_RD) && (count != '0);
   assign next_count = count + CW'(push) - CW'(pop);
   assign head       = wb_entry_t'(head_bits);

   wb_fifo #(
      .WIDTH(EW),
      .DEPTH(QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (in_entry),
      .pop       (pop),
      .head      (head_bits),
      .count     (count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         rf_reg_write  <= 1'b0;
         rf_write_reg  <= '0;
         rf_write_data <= '0;
         rf_read_reg   <= '0;
         busy          <= 1'b0;
         pend_byte     <= '0;
         pend_lane     <= '0;
      end else begin
         rf_reg_write <= 1'b0;
         rf_read_reg  <= '0;
         case (state)
            ST_IDLE, ST_WR: begin
               if (pop && head.rd == 5'd0) begin
                  // Writes to $zero are dropped without a read or a write pulse.
                  state <= ST_IDLE;
                  busy  <= (next_count != '0);
               end else if (pop && head.is_byte) begin
                  state       <= ST_RD;
                  rf_read_reg <= head.rd;
                  pend_byte   <= head.data[7:0];
                  pend_lane   <= head.lane;
                  busy        <= 1'b1;
               end else if (pop) begin
                  state         <= ST_WR;
                  rf_reg_write  <= 1'b1;
                  rf_write_reg  <= head.rd;
                  rf_write_data <= head.data;
                  busy          <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  busy  <= (next_count != '0);
               end
            end
            ST_RD: begin
               state         <= ST_WR;
               rf_reg_write  <= 1'b1;
               rf_write_reg  <= rf_read_reg;
               rf_write_data <= merge_byte(rf_read_data, pend_byte, pend_lane);
               busy          <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= (next_count != '0);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - self-checking bench for reg_writeback_unit
module tb_reg_writeback_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [4:0]  wb_reg = '0;
   logic [31:0] wb_data = '0;
   logic        wb_byte = 1'b0;
   logic [1:0]  wb_byte_sel = '0;
   logic [4:0]  rf_read_reg;
   logic [31:0] rf_read_data;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic        rf_reg_write;
   logic        busy;

   reg_writeback_unit #(.QDEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb_valid      (wb_valid),
      .wb_ready      (wb_ready),
      .wb_reg        (wb_reg),
      .wb_data       (wb_data),
      .wb_byte       (wb_byte),
      .wb_byte_sel   (wb_byte_sel),
      .rf_read_reg   (rf_read_reg),
      .rf_read_data  (rf_read_data),
      .rf_write_reg  (rf_write_reg),
      .rf_write_data (rf_write_data),
      .rf_reg_write  (rf_reg_write),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      int          c;
   } wr_t;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      bit          b;
      logic [1:0]  s;
      bit          exp_wr;
      logic [31:0] exp_d;
      int          lat;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          wbase = 0;
   int          rbase = 0;
   wr_t         wlog[$];
   wr_t         rlog[$];
   wr_t         exp_q[$];
   logic [31:0] rf [32];
   logic [31:0] model_rf [32];
   vec_t        vecs [8];

   function automatic logic [31:0] init_val(input int i);
      return (i == 7) ? 32'h11223344 : 32'(i) * 32'h9E3779B1;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [7:0] b,
                                             input logic [1:0] s);
      logic [31:0] t;
      t = old;
      t[int'(s) * 8 +: 8] = b;
      return t;
   endfunction

   // Register file environment: reloaded with known contents while reset is held.
   assign rf_read_data = rf[rf_read_reg];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= init_val(i);
      end else if (rf_reg_write) begin
         rf[rf_write_reg] <= rf_write_data;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rf_reg_write === 1'b1) wlog.push_back('{rf_write_reg, rf_write_data, cyc});
      if (rf_read_reg !== 5'd0) rlog.push_back('{rf_read_reg, 32'd0, cyc});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic model_accept(input logic [4:0] r, input logic [31:0] d, input bit b,
                               input logic [1:0] s);
      logic [31:0] v;
      if (r != 5'd0) begin
         v = b ? ref_merge(model_rf[r], d[7:0], s) : d;
         model_rf[r] = v;
         exp_q.push_back('{r, v, 0});
      end
   endtask

   task automatic drive(input bit v, input logic [4:0] r, input logic [31:0] d, input bit b,
                        input logic [1:0] s, output bit acc, output int edge_n);
      @(negedge clk);
      wb_valid    = v;
      wb_reg      = r;
      wb_data     = d;
      wb_byte     = b;
      wb_byte_sel = s;
      acc         = v && (wb_ready === 1'b1);
      edge_n      = cyc + 1;
      if (acc) model_accept(r, d, b, s);
   endtask

   task automatic idle(input int n);
      bit acc;
      int e;
      for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 2'd0, acc, e);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         idle(1);
         n++;
      end while (busy !== 1'b0 && n < budget);
      chk("drain_busy", {31'd0, busy}, 32'd0);
   endtask

   // Caller must be at a falling edge; log bases move past anything already observed.
   task automatic do_reset_now();
      reset    = 1'b1;
      wb_valid = 1'b0;
      #1;
      wbase = wlog.size();
      rbase = rlog.size();
      exp_q.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
      @(negedge clk);
      chk("reset_ready_next", {31'd0, wb_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      do_reset_now();
   endtask

   task automatic check_log(input string name);
      int n;
      n = wlog.size() - wbase;
      chk({name, "_count"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         chk({name, "_reg"}, wlog[wbase + i].r, exp_q[i].r);
         chk({name, "_data"}, wlog[wbase + i].d, exp_q[i].d);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int e;
      int e0;
      int k;
      int tries;
      bit saw_full;

      vecs[0] = '{5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 1'b1, 32'hDEADBEEF, 1};
      vecs[1] = '{5'd7, 32'h000000AB, 1'b1, 2'd0, 1'b1, 32'h112233AB, 2};
      vecs[2] = '{5'd7, 32'h000000AB, 1'b1, 2'd1, 1'b1, 32'h1122AB44, 2};
      vecs[3] = '{5'd7, 32'h000000AB, 1'b1, 2'd2, 1'b1, 32'h11AB3344, 2};
      vecs[4] = '{5'd7, 32'h000000AB, 1'b1, 2'd3, 1'b1, 32'hAB223344, 2};
      vecs[5] = '{5'd7, 32'hFFFFFF5A, 1'b1, 2'd1, 1'b1, 32'h11225A44, 2};
      vecs[6] = '{5'd0, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b0, 32'h0, 0};
      vecs[7] = '{5'd0, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0, 32'h0, 0};

      do_reset();
      chk("rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
      chk("rst_rf_write_reg", rf_write_reg, 32'd0);
      chk("rst_rf_write_data", rf_write_data, 32'd0);
      chk("rst_rf_read_reg", rf_read_reg, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_wb_ready", {31'd0, wb_ready}, 32'd1);

      foreach (vecs[i]) begin
         do_reset();
         drive(1'b1, vecs[i].r, vecs[i].d, vecs[i].b, vecs[i].s, acc, e0);
         chk("vec_accept", {31'd0, acc}, 32'd1);
         idle(6);
         chk("vec_write_count", wlog.size() - wbase, {31'd0, vecs[i].exp_wr});
         if (vecs[i].exp_wr && wlog.size() > wbase) begin
            chk("vec_reg", wlog[wbase].r, vecs[i].r);
            chk("vec_data", wlog[wbase].d, vecs[i].exp_d);
            chk("vec_latency", wlog[wbase].c, e0 + vecs[i].lat);
         end
         chk("vec_read_count", rlog.size() - rbase, (vecs[i].b && vecs[i].exp_wr) ? 32'd1 : 32'd0);
         if (vecs[i].b && rlog.size() > rbase) begin
            chk("vec_read_reg", rlog[rbase].r, vecs[i].r);
            chk("vec_read_cycle", rlog[rbase].c, e0 + 1);
         end
         chk("vec_busy_idle", {31'd0, busy}, 32'd0);
      end

      // Back-to-back word writes retire one per cycle.
      do_reset();
      drive(1'b1, 5'd1, 32'hA0000001, 1'b0, 2'd0, acc, e0);
      for (int i = 2; i <= 4; i++) drive(1'b1, 5'(i), 32'hA0000000 | 32'(i), 1'b0, 2'd0, acc, e);
      wait_idle(20);
      check_log("burst");
      for (int i = 0; i < 4 && wbase + i < wlog.size(); i++)
         chk("burst_cycle", wlog[wbase + i].c, e0 + 1 + i);

      // Byte stream outpaces the two-cycle RMW until the queue fills; held offer then drains in order.
      do_reset();
      k = 0;
      tries = 0;
      saw_full = 1'b0;
      while (k < 14 && tries < 60) begin
         drive(1'b1, 5'(k + 1), $urandom, (k < 10), 2'(k), acc, e);
         if (acc) k++;
         else saw_full = 1'b1;
         tries++;
      end
      chk("full_seen", {31'd0, saw_full}, 32'd1);
      wait_idle(60);
      check_log("full");

      // Byte RMW right behind a word write to the same register sees the new value.
      do_reset();
      drive(1'b1, 5'd9, 32'h00000000, 1'b0, 2'd0, acc, e);
      drive(1'b1, 5'd9, 32'h0000005A, 1'b1, 2'd0, acc, e);
      wait_idle(20);
      check_log("raw");
      if (wlog.size() - wbase == 2) chk("raw_second", wlog[wbase + 1].d, 32'h0000005A);

      // Reset while a byte RMW is in RD with three requests still queued.
      do_reset();
      for (int i = 0; i < 6; i++) drive(1'b1, 5'(i + 3), $urandom, 1'b1, 2'(i), acc, e);
      @(negedge clk);
      chk("mid_rd_reg", rf_read_reg, 32'd5);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      do_reset_now();
      idle(10);
      chk("post_rst_writes", wlog.size() - wbase, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_ready", {31'd0, wb_ready}, 32'd1);

      // Random traffic against the in-order register file model.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), acc, e);
      end
      wait_idle(100);
      check_log("rand");

      do_reset();
      for (int i = 0; i < 200; i++) begin
         drive(1'b1, 5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), acc, e);
      end
      wait_idle(100);
      check_log("rand_hot");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
